// File: rtl/repsub_div.sv
// Unsigned divider by repeated subtraction; dividend then divisor arrive on din.
// Optional REPSUB_DBZ_FLAG_EN raises err on a divide-by-zero, otherwise err is tied low.
//
//   state | meaning
//   IDLE  | waiting for start
//   LDA   | capture dividend into remainder, clear quotient
//   LDB   | capture divisor; zero divisor jumps straight to DONE
//   SUB   | subtract divisor while remainder >= divisor
//   DONE  | results held until the next start

module repsub_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    SUB  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] divisor;
  logic             sub_ok;
  logic             din_zero;

  assign sub_ok   = (remainder >= divisor);
  assign din_zero = (din == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LDA;
      LDA:     state_nxt = LDB;
      LDB:     state_nxt = din_zero ? DONE : SUB;
      SUB:     if (!sub_ok) state_nxt = DONE;
      DONE:    if (start) state_nxt = LDA;
      default: state_nxt = IDLE;
    endcase
  end

  // Guarded subtraction: remainder never underflows and quotient tops out at divisor==1.
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      divisor   <= '0;
    end else begin
      case (state)
        LDA: begin
          remainder <= din;
          quotient  <= '0;
        end
        LDB: begin
          divisor <= din;
          if (din_zero) quotient <= '1;
        end
        SUB: begin
          if (sub_ok) begin
            remainder <= remainder - divisor;
            quotient  <= quotient + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef REPSUB_DBZ_FLAG_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst)                          err_q <= 1'b0;
    else if (state == LDA)            err_q <= 1'b0;
    else if (state == LDB && din_zero) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy = (state == LDA) || (state == LDB) || (state == SUB);
  assign done = (state == DONE);

endmodule

// File: tb/tb_repsub_div.sv
// Scoreboard bench for repsub_div: driver pushes expected q/r/err/done-cycle, monitor pops on done rise.
module tb_repsub_div;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] din;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         err;

  repsub_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         e;
    int           t;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising edge of done must match the oldest pending expectation.
  logic done_d = 1'b0;
  always @(negedge clk) begin
    if (!rst && done && !done_d) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done with empty scoreboard at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("err", err, e.e);
        check("done_cycle", cyc, e.t);
        check("busy_in_done", busy, 1'b0);
      end
    end
    done_d <= done;
  end

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sbq.delete();
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
  endtask

  // Reference: plain integer division; zero divisor gives all-ones quotient and the dividend back.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit noise, input int abort_after);
    exp_t e;
    int   lim;
    @(negedge clk);
    start = 1'b1;
    din   = W'($urandom);
    @(posedge clk);
    @(negedge clk);
    if (b == 0) begin
      e.q = '1;
      e.r = a;
      e.t = cyc + 2;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.t = cyc + 3 + int'(a / b);
    end
`ifdef REPSUB_DBZ_FLAG_EN
    e.e = (b == 0);
`else
    e.e = 1'b0;
`endif
    sbq.push_back(e);
    lim = e.t - cyc + 5;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
    start = noise ? 1'($urandom) : 1'b0;
    din   = a;
    @(negedge clk);
    start = noise ? 1'($urandom) : 1'b0;
    din   = b;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (k == abort_after) begin
        do_reset();
        return;
      end
      if (done) break;
      start = noise ? 1'($urandom) : 1'b0;
      din   = noise ? W'($urandom) : din;
    end
    start = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: done not seen for %0d / %0d within %0d cycles", a, b, lim);
      do_reset();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    rst   = 1'b1;
    start = 1'b0;
    din   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("init_quotient", quotient, 0);
    check("init_remainder", remainder, 0);
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    check("init_err", err, 0);
    rst = 1'b0;

    run_op(16'd100, 16'd7, 1'b0, -1);
    run_op(16'd5, 16'd9, 1'b0, -1);
    run_op(16'd1234, 16'd0, 1'b0, -1);
    run_op(16'd100, 16'd7, 1'b1, -1);
    run_op(16'd9, 16'd3, 1'b0, -1);
    repeat (3) @(negedge clk);
    check("hold_quotient", quotient, 3);
    check("hold_remainder", remainder, 0);
    check("hold_done", done, 1);
    run_op(16'd0, 16'd17, 1'b0, -1);
    run_op(16'd1000, 16'd1, 1'b0, 50);
    run_op(16'd77, 16'd8, 1'b0, -1);
    run_op(16'd65535, 16'd1, 1'b0, -1);

    for (int i = 0; i < 30; i++) begin
      a = W'($urandom);
      b = W'(a >> $urandom_range(0, 6)) + W'($urandom_range(0, 3));
      run_op(a, b, 1'($urandom), -1);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
